// File: rtl/lcd_result_fmt_pkg.sv
// Shared constants, FSM encoding and elaboration-time helpers for the LCD result formatter.
package lcd_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] LSD_OVF     = 8'h0F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // ceil(w*log10(2)) + 1 nibbles hold 2^(w-1) in BCD
    function automatic int bcd_nibbles(input int w);
        return (w * 30103 + 99999) / 100000 + 1;
    endfunction

    function automatic logic [63:0] pow10_m1(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/lcd_result_fmt_if.sv
// Valid/ready request channel carrying a signed result into the formatter.
interface lcd_result_fmt_if #(
    parameter int RES_W = 8
);
    logic [RES_W-1:0] res_in;
    logic             res_valid;
    logic             res_ready;

    modport master (output res_in, output res_valid, input  res_ready);
    modport slave  (input  res_in, input  res_valid, output res_ready);
endinterface

// File: rtl/lcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
module lcd_dd_step #(
    parameter int NIB   = 4,
    parameter int BIN_W = 8
) (
    input  logic [NIB*4-1:0] bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic [NIB*4-1:0] bcd_out,
    output logic [BIN_W-1:0] bin_out
);

    logic [NIB-1:0][3:0] adj;

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        assign adj[g] = (bcd_in[g*4 +: 4] >= 4'd5) ? bcd_in[g*4 +: 4] + 4'd3
                                                   : bcd_in[g*4 +: 4];
    end

    assign {bcd_out, bin_out} = {adj, bin_in} << 1;

endmodule

// File: rtl/lcd_result_fmt.sv
// Signed result -> leading-blank ASCII digits for the 16x2 LCD writer, via sequential double-dabble.
module lcd_result_fmt
    import lcd_pkg::*;
#(
    parameter int RES_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd_result_fmt_if.slave       req,
    output logic [DIGITS*8-1:0]   digits_ascii,
    output logic [7:0]            digit_lsd,
    output logic                  neg_sign,
    output logic                  overflow,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int NIB_MIN = bcd_nibbles(RES_W);
    localparam int NIB     = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS;
    localparam int CNT_W   = (RES_W > 2) ? $clog2(RES_W) : 1;
    localparam logic [63:0] MAX_VAL = pow10_m1(DIGITS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [RES_W-1:0]   mag_q, mag_in, bin_nxt;
    logic [NIB*4-1:0]   bcd_q, bcd_nxt;
    logic               sign_q, ovf_q, ovf_in;
    logic               load, done, last;
    logic [DIGITS*8-1:0] fmt_ascii;
    logic [7:0]         fmt_lsd;
    logic               blank;
    logic [3:0]         nib;

    assign req.res_ready = rst_n & (state_q == ST_IDLE);
    assign busy          = (state_q == ST_CONV);
    assign last          = (cnt_q == CNT_W'(RES_W - 1));

    // Two's-complement negate in RES_W bits: the most negative value maps onto its unsigned magnitude.
    assign mag_in = req.res_in[RES_W-1] ? (RES_W'(0) - req.res_in) : req.res_in;
    assign ovf_in = (64'(mag_in) > MAX_VAL);

    lcd_dd_step #(.NIB(NIB), .BIN_W(RES_W)) u_step (
        .bcd_in  (bcd_q),
        .bin_in  (mag_q),
        .bcd_out (bcd_nxt),
        .bin_out (bin_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (req.res_valid) begin
                load    = 1'b1;
                state_d = ST_CONV;
            end
            ST_CONV: if (last) begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Format from the final-shift BCD so outputs land on the same edge as the last shift.
    always_comb begin
        fmt_ascii = '0;
        blank     = 1'b1;
        nib       = 4'h0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = bcd_nxt[k*4 +: 4];
            if (ovf_q) begin
                fmt_ascii[k*8 +: 8] = ASCII_STAR;
            end else if (blank && nib == 4'h0 && k != 0) begin
                fmt_ascii[k*8 +: 8] = ASCII_SPACE;
            end else begin
                blank = 1'b0;
                fmt_ascii[k*8 +: 8] = ASCII_ZERO | {4'h0, nib};
            end
        end
        fmt_lsd = ovf_q ? LSD_OVF : {4'h0, bcd_nxt[3:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            mag_q        <= '0;
            bcd_q        <= '0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            digits_ascii <= {DIGITS{ASCII_SPACE}};
            digit_lsd    <= 8'h00;
            neg_sign     <= 1'b0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (load) begin
                sign_q <= req.res_in[RES_W-1];
                mag_q  <= mag_in;
                ovf_q  <= ovf_in;
                bcd_q  <= '0;
                cnt_q  <= '0;
            end else if (state_q == ST_CONV) begin
                bcd_q  <= bcd_nxt;
                mag_q  <= bin_nxt;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (done) begin
                digits_ascii <= fmt_ascii;
                digit_lsd    <= fmt_lsd;
                neg_sign     <= sign_q;
                overflow     <= ovf_q;
                out_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_result_fmt.sv
// Directed bench: one 3-digit and one 2-digit formatter fed the same vectors, checked against hand values.
module tb_lcd_result_fmt;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    lcd_result_fmt_if #(.RES_W(8)) a3 ();
    lcd_result_fmt_if #(.RES_W(8)) a2 ();

    logic [23:0] dig3;
    logic [15:0] dig2;
    logic [7:0]  lsd3, lsd2;
    logic        neg3, neg2, ovf3, ovf2, ov3, ov2, busy3, busy2;

    lcd_result_fmt #(.RES_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(a3.slave),
        .digits_ascii(dig3), .digit_lsd(lsd3), .neg_sign(neg3),
        .overflow(ovf3), .out_valid(ov3), .busy(busy3)
    );

    lcd_result_fmt #(.RES_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(a2.slave),
        .digits_ascii(dig2), .digit_lsd(lsd2), .neg_sign(neg2),
        .overflow(ovf2), .out_valid(ov2), .busy(busy2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [7:0]  v;
        logic [23:0] a3;
        logic [7:0]  l3;
        logic        n;
        logic        o3;
        logic [15:0] a2;
        logic [7:0]  l2;
        logic        o2;
    } vec_t;

    vec_t vecs [10];

    task automatic drive(input logic [7:0] v, input logic vld);
        a3.res_in = v; a3.res_valid = vld;
        a2.res_in = v; a2.res_valid = vld;
    endtask

    // Counts edges after the accept edge until out_valid is seen; expected latency is RES_W.
    task automatic wait_ov(input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ov3 && lat < 20);
        chk(tag, 64'(lat), 64'd8);
        chk({tag, "_ov2"}, 64'(ov2), 64'd1);
    endtask

    task automatic do_conv(input vec_t e, input int idx);
        int w;
        @(negedge clk);
        drive(e.v, 1'b1);
        w = 0;
        while (!a3.res_ready && w < 20) begin @(negedge clk); w++; end
        chk($sformatf("rdy_%0d", idx), 64'(a3.res_ready), 64'd1);
        @(posedge clk); #1;
        drive(e.v, 1'b0);
        chk($sformatf("busy_%0d", idx), 64'(busy3), 64'd1);
        wait_ov($sformatf("lat_%0d", idx));
        chk($sformatf("dig3_%0d", idx), 64'(dig3), 64'(e.a3));
        chk($sformatf("lsd3_%0d", idx), 64'(lsd3), 64'(e.l3));
        chk($sformatf("neg3_%0d", idx), 64'(neg3), 64'(e.n));
        chk($sformatf("ovf3_%0d", idx), 64'(ovf3), 64'(e.o3));
        chk($sformatf("dig2_%0d", idx), 64'(dig2), 64'(e.a2));
        chk($sformatf("lsd2_%0d", idx), 64'(lsd2), 64'(e.l2));
        chk($sformatf("ovf2_%0d", idx), 64'(ovf2), 64'(e.o2));
        @(posedge clk); #1;
        chk($sformatf("ovlow_%0d", idx), 64'(ov3), 64'd0);
        chk($sformatf("hold_%0d", idx), 64'(dig3), 64'(e.a3));
    endtask

    initial begin
        int acc;
        int seen;
        //          value   3-digit ascii lsd  neg ovf  2-digit  lsd  ovf
        vecs[0] = '{8'd123, 24'h313233, 8'h03, 1'b0, 1'b0, 16'h2A2A, 8'h0F, 1'b1};
        vecs[1] = '{8'h80,  24'h313238, 8'h08, 1'b1, 1'b0, 16'h2A2A, 8'h0F, 1'b1};
        vecs[2] = '{8'h00,  24'h202030, 8'h00, 1'b0, 1'b0, 16'h2030, 8'h00, 1'b0};
        vecs[3] = '{8'hFB,  24'h202035, 8'h05, 1'b1, 1'b0, 16'h2035, 8'h05, 1'b0};
        vecs[4] = '{8'd100, 24'h313030, 8'h00, 1'b0, 1'b0, 16'h2A2A, 8'h0F, 1'b1};
        vecs[5] = '{8'd99,  24'h203939, 8'h09, 1'b0, 1'b0, 16'h3939, 8'h09, 1'b0};
        vecs[6] = '{8'h7F,  24'h313237, 8'h07, 1'b0, 1'b0, 16'h2A2A, 8'h0F, 1'b1};
        vecs[7] = '{8'h9C,  24'h313030, 8'h00, 1'b1, 1'b0, 16'h2A2A, 8'h0F, 1'b1};
        vecs[8] = '{8'h0A,  24'h203130, 8'h00, 1'b0, 1'b0, 16'h3130, 8'h00, 1'b0};
        vecs[9] = '{8'hFF,  24'h202031, 8'h01, 1'b1, 1'b0, 16'h2031, 8'h01, 1'b0};

        drive(8'h00, 1'b0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dig3", 64'(dig3), 64'h202020);
        chk("rst_dig2", 64'(dig2), 64'h2020);
        chk("rst_lsd",  64'(lsd3), 64'h0);
        chk("rst_flags", 64'({neg3, ovf3, ov3, busy3}), 64'h0);
        chk("rst_rdy",  64'(a3.res_ready), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rdy_after_rst", 64'(a3.res_ready), 64'h1);

        for (int i = 0; i < 10; i++) do_conv(vecs[i], i);

        // res_valid held through busy: one accept per conversion
        @(negedge clk);
        drive(8'd45, 1'b1);
        @(posedge clk); #1;
        drive(8'hF9, 1'b1);
        acc = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (a3.res_ready) acc++;
            chk($sformatf("hold_rdy_%0d", k), 64'(a3.res_ready), 64'(k == 9));
            @(posedge clk); #1;
            if (k == 8) begin
                chk("hold_ov_a", 64'(ov3), 64'd1);
                chk("hold_dig_a", 64'(dig3), 64'h203435);
            end
        end
        drive(8'hF9, 1'b0);
        chk("hold_accepts", 64'(acc), 64'd1);
        wait_ov("hold_lat_b");
        chk("hold_dig_b", 64'(dig3), 64'h202037);
        chk("hold_neg_b", 64'(neg3), 64'd1);

        // reset in the middle of a conversion
        @(negedge clk);
        drive(8'd123, 1'b1);
        @(posedge clk); #1;
        drive(8'd123, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dig3", 64'(dig3), 64'h202020);
        chk("mid_rst_dig2", 64'(dig2), 64'h2020);
        chk("mid_rst_flags", 64'({lsd3, neg3, ovf3, busy3, a3.res_ready}), 64'h0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov3 || ov2) seen++;
            if (k == 3) rst_n = 1'b1;
        end
        chk("mid_rst_no_ov", 64'(seen), 64'd0);
        do_conv(vecs[3], 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
